branch_hazard_ctrl: RTL and testbench
=====================================

Name: branch_hazard_ctrl

Overview:
Control-side counterpart of the program counter. Resolves branches and jumps in EX and drives the PC redirect interface (succ, new_addr as a PC-relative offset, stall). Also detects load-use hazards between ID and EX and squashes wrong-path instructions after a redirect.

Parameters:
FLUSH_DEPTH, 2, number of cycles after a redirect during which EX-valid instructions are treated as wrong-path and ignored (1..7).
CNT_W, 3, width of the squash down-counter; must hold FLUSH_DEPTH.

Ports:
clock  input  1  rising-edge clock
reset  input  1  asynchronous, active-high reset
ex_valid  input  1  EX stage holds a real instruction
ex_is_branch  input  1  conditional branch in EX
ex_is_jal  input  1  JAL in EX
ex_is_jalr  input  1  JALR in EX
ex_funct3  input  3  branch condition: 000 BEQ, 001 BNE, 100 BLT, 101 BGE, 110 BLTU, 111 BGEU
ex_rs1_val  input  32  forwarded rs1 operand
ex_rs2_val  input  32  forwarded rs2 operand
ex_imm  input  32  sign-extended immediate
ex_pc  input  32  address of the EX instruction
ex_is_load  input  1  EX instruction is a load
ex_rd  input  5  EX destination register
id_rs1  input  5  ID source register 1
id_rs2  input  5  ID source register 2
id_uses_rs1  input  1  ID instruction reads rs1
id_uses_rs2  input  1  ID instruction reads rs2
succ  output  1  redirect PC, one-cycle pulse
new_addr  output  32  target minus ex_pc, valid while succ=1
stall  output  1  hold PC and IF/ID, one-cycle pulse
flush  output  1  squash IF/ID and ID/EX contents
bubble  output  1  insert NOP into ID/EX (load-use)
misalign  output  1  target not word-aligned, one-cycle pulse

Behaviour:
- All outputs are registered. Reset clears succ, new_addr, stall, flush, bubble, and misalign to 0, sets the state to RUN, and sets the counter to 0. Reset is asynchronous and takes effect immediately, including in SQUASH.
- Decision (combinational, sampled at posedge):
  - Branch taken per ex_funct3. BLT and BGE compare signed; BLTU and BGEU compare unsigned. Undefined funct3 values (010, 011) are not taken.
  - JAL target = ex_pc + ex_imm.
  - JALR target = (ex_rs1_val + ex_imm) with bit 0 cleared.
  - Branch target = ex_pc + ex_imm.
  - offset = target - ex_pc, modulo 2^32. Wrap-around is permitted.
- take = ex_valid & (ex_is_jal | ex_is_jalr | (ex_is_branch & cond)).
- State RUN:
  - take and target[1]=0: next cycle succ=1, new_addr=offset, flush=1; load counter with FLUSH_DEPTH; go to SQUASH.
  - take and target[1]=1: misalign=1 for one cycle; no succ and no flush; stay in RUN.
  - Otherwise, load-use (ex_valid & ex_is_load & ex_rd!=0 & ((id_uses_rs1 & id_rs1==ex_rd) | (id_uses_rs2 & id_rs2==ex_rd))): next cycle stall=1 and bubble=1 for exactly one cycle.
  - Redirect has priority over load-use. Both are never asserted in the same cycle.
- State SQUASH:
  - Decrement the counter each cycle. EX inputs are ignored: no succ, stall, or misalign, even if ex_valid=1.
  - flush stays asserted only in the first SQUASH cycle.
  - When the counter reaches 1, return to RUN on the next edge.
  - Latency: a new redirect can be issued FLUSH_DEPTH+1 cycles after the previous one at the earliest.
- Latency: one cycle from the EX sample to the output pulse. Pulses deassert the following cycle unless re-triggered in RUN.
- Back-to-back load-use in RUN, with the same EX load held: stall re-asserts each cycle while the condition holds.

Optional Feature:
BRANCH_STATS_EN:
- Defined: adds outputs taken_count[31:0] and stall_count[31:0]. They are cleared by reset, increment on each succ pulse and each stall pulse respectively, and wrap from 0xFFFFFFFF to 0.
- Undefined: these ports and their logic are absent; all other behaviour is identical.

Test Plan:
- BEQ taken: ex_pc=0x00400010, ex_imm=0x20, rs1=rs2=5, ex_valid=1 -> next cycle succ=1, new_addr=0x20, flush=1; EX instructions ignored for 2 cycles; RUN on the 3rd.
- BLT signed vs BLTU: rs1=0xFFFFFFFF, rs2=1 -> BLT taken (succ=1); BLTU not taken (succ=0).
- JALR alignment: rs1=0x00400101, imm=0 -> target 0x00400100, ex_pc=0x00400040 -> new_addr=0xC0. With rs1=0x00400102 -> misalign=1, succ=0.
- Load-use: ex_is_load=1, ex_rd=7, id_rs2=7, id_uses_rs2=1 -> stall=1 and bubble=1 for one cycle. With ex_rd=0 -> no stall.
- Priority and squash: a taken JAL in the same cycle as a load-use match -> succ=1, stall=0. A taken branch presented during SQUASH -> no succ.
- Reset mid-SQUASH: assert reset in the first SQUASH cycle -> all outputs 0 immediately. After release, a taken branch redirects normally in RUN.

Source files
------------

// File: rtl/branch_hazard_ctrl.sv
// branch_hazard_ctrl
// Resolves branches and jumps in EX and drives the PC redirect interface
// (succ / new_addr as a PC-relative offset / flush). Detects ID-vs-EX
// load-use hazards (stall / bubble) and, after a redirect, ignores the
// wrong-path instructions that reach EX for FLUSH_DEPTH cycles.
//
// Optional feature macro: BRANCH_STATS_EN adds taken_count / stall_count.
//
// Ports:
//   clock, reset          rising-edge clock, asynchronous active-high reset
//   ex_valid              EX holds a real instruction
//   ex_is_branch/jal/jalr control-transfer type in EX
//   ex_funct3             branch condition
//   ex_rs1_val/rs2_val    forwarded operands
//   ex_imm, ex_pc         immediate and address of the EX instruction
//   ex_is_load, ex_rd     EX load and its destination
//   id_rs1/rs2, id_uses_* ID source registers and their use flags
//   succ, new_addr        redirect pulse and target offset from ex_pc
//   stall, bubble         load-use hold / NOP insertion pulse
//   flush                 squash IF/ID and ID/EX
//   misalign              taken target not word-aligned
//   taken_count, stall_count (BRANCH_STATS_EN only) event counters
module branch_hazard_ctrl #(
    parameter int unsigned FLUSH_DEPTH = 2,
    parameter int unsigned CNT_W       = 3
) (
    input  logic        clock,
    input  logic        reset,
    input  logic        ex_valid,
    input  logic        ex_is_branch,
    input  logic        ex_is_jal,
    input  logic        ex_is_jalr,
    input  logic [2:0]  ex_funct3,
    input  logic [31:0] ex_rs1_val,
    input  logic [31:0] ex_rs2_val,
    input  logic [31:0] ex_imm,
    input  logic [31:0] ex_pc,
    input  logic        ex_is_load,
    input  logic [4:0]  ex_rd,
    input  logic [4:0]  id_rs1,
    input  logic [4:0]  id_rs2,
    input  logic        id_uses_rs1,
    input  logic        id_uses_rs2,
    output logic        succ,
    output logic [31:0] new_addr,
    output logic        stall,
    output logic        flush,
    output logic        bubble,
    output logic        misalign
`ifdef BRANCH_STATS_EN
    ,
    output logic [31:0] taken_count,
    output logic [31:0] stall_count
`endif
);

    localparam int unsigned XLEN = 32;

    typedef enum logic {
        RUN    = 1'b0,
        SQUASH = 1'b1
    } state_t;

    state_t            state_q, state_d;
    logic [CNT_W-1:0]  cnt_q, cnt_d;
    logic              succ_q, succ_d;
    logic [XLEN-1:0]   new_addr_q, new_addr_d;
    logic              stall_q, stall_d;
    logic              flush_q, flush_d;
    logic              bubble_q, bubble_d;
    logic              misalign_q, misalign_d;

    logic              cond_c;
    logic              take_c;
    logic              load_use_c;
    logic [XLEN-1:0]   jalr_sum_c;
    logic [XLEN-1:0]   target_c;
    logic [XLEN-1:0]   offset_c;

    // Branch condition evaluation
    always_comb begin
        cond_c = 1'b0;
        case (ex_funct3)
            3'b000:  cond_c = (ex_rs1_val == ex_rs2_val);
            3'b001:  cond_c = (ex_rs1_val != ex_rs2_val);
            3'b100:  cond_c = ($signed(ex_rs1_val) <  $signed(ex_rs2_val));
            3'b101:  cond_c = ($signed(ex_rs1_val) >= $signed(ex_rs2_val));
            3'b110:  cond_c = (ex_rs1_val <  ex_rs2_val);
            3'b111:  cond_c = (ex_rs1_val >= ex_rs2_val);
            default: cond_c = 1'b0;
        endcase
    end

    // Target / offset and hazard detection
    always_comb begin
        jalr_sum_c = ex_rs1_val + ex_imm;
        target_c   = ex_is_jalr ? {jalr_sum_c[XLEN-1:1], 1'b0} : (ex_pc + ex_imm);
        offset_c   = target_c - ex_pc;
        take_c     = ex_valid & (ex_is_jal | ex_is_jalr | (ex_is_branch & cond_c));
        load_use_c = ex_valid & ex_is_load & (ex_rd != 5'd0)
                   & ((id_uses_rs1 & (id_rs1 == ex_rd)) | (id_uses_rs2 & (id_rs2 == ex_rd)));
    end

    // Next-state and output decision
    always_comb begin
        state_d    = state_q;
        cnt_d      = cnt_q;
        succ_d     = 1'b0;
        new_addr_d = '0;
        stall_d    = 1'b0;
        flush_d    = 1'b0;
        bubble_d   = 1'b0;
        misalign_d = 1'b0;

        case (state_q)
            RUN: begin
                if (take_c && !target_c[1]) begin
                    succ_d     = 1'b1;
                    new_addr_d = offset_c;
                    flush_d    = 1'b1;
                    cnt_d      = CNT_W'(FLUSH_DEPTH);
                    state_d    = SQUASH;
                end else if (take_c) begin
                    misalign_d = 1'b1;
                end else if (load_use_c) begin
                    stall_d  = 1'b1;
                    bubble_d = 1'b1;
                end
            end
            SQUASH: begin
                // EX is wrong-path here; flush was already issued with succ
                cnt_d = cnt_q - CNT_W'(1);
                if (cnt_q == CNT_W'(1)) begin
                    state_d = RUN;
                end
            end
            default: begin
                state_d = RUN;
                cnt_d   = '0;
            end
        endcase
    end

    // State and output registers
    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            state_q    <= RUN;
            cnt_q      <= '0;
            succ_q     <= 1'b0;
            new_addr_q <= '0;
            stall_q    <= 1'b0;
            flush_q    <= 1'b0;
            bubble_q   <= 1'b0;
            misalign_q <= 1'b0;
        end else begin
            state_q    <= state_d;
            cnt_q      <= cnt_d;
            succ_q     <= succ_d;
            new_addr_q <= new_addr_d;
            stall_q    <= stall_d;
            flush_q    <= flush_d;
            bubble_q   <= bubble_d;
            misalign_q <= misalign_d;
        end
    end

    assign succ     = succ_q;
    assign new_addr = new_addr_q;
    assign stall    = stall_q;
    assign flush    = flush_q;
    assign bubble   = bubble_q;
    assign misalign = misalign_q;

`ifdef BRANCH_STATS_EN
    logic [XLEN-1:0] taken_count_q, stall_count_q;

    // Counters step together with the pulse they count (wrap naturally)
    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            taken_count_q <= '0;
            stall_count_q <= '0;
        end else begin
            taken_count_q <= taken_count_q + XLEN'(succ_d);
            stall_count_q <= stall_count_q + XLEN'(stall_d);
        end
    end

    assign taken_count = taken_count_q;
    assign stall_count = stall_count_q;
`endif

endmodule

// File: tb/tb_branch_hazard_ctrl.sv
// Testbench for branch_hazard_ctrl: directed scenarios followed by random
// stimulus, all checked against a cycle-level reference model.
module tb_branch_hazard_ctrl;

    localparam int unsigned FLUSH_DEPTH = 2;
    localparam int unsigned CNT_W       = 3;

    logic        clock;
    logic        reset;
    logic        ex_valid, ex_is_branch, ex_is_jal, ex_is_jalr;
    logic [2:0]  ex_funct3;
    logic [31:0] ex_rs1_val, ex_rs2_val, ex_imm, ex_pc;
    logic        ex_is_load;
    logic [4:0]  ex_rd, id_rs1, id_rs2;
    logic        id_uses_rs1, id_uses_rs2;
    logic        succ, stall, flush, bubble, misalign;
    logic [31:0] new_addr;
`ifdef BRANCH_STATS_EN
    logic [31:0] taken_count, stall_count;
`endif

    branch_hazard_ctrl #(.FLUSH_DEPTH(FLUSH_DEPTH), .CNT_W(CNT_W)) dut (
        .clock(clock), .reset(reset),
        .ex_valid(ex_valid), .ex_is_branch(ex_is_branch), .ex_is_jal(ex_is_jal),
        .ex_is_jalr(ex_is_jalr), .ex_funct3(ex_funct3),
        .ex_rs1_val(ex_rs1_val), .ex_rs2_val(ex_rs2_val), .ex_imm(ex_imm), .ex_pc(ex_pc),
        .ex_is_load(ex_is_load), .ex_rd(ex_rd), .id_rs1(id_rs1), .id_rs2(id_rs2),
        .id_uses_rs1(id_uses_rs1), .id_uses_rs2(id_uses_rs2),
        .succ(succ), .new_addr(new_addr), .stall(stall), .flush(flush),
        .bubble(bubble), .misalign(misalign)
`ifdef BRANCH_STATS_EN
        , .taken_count(taken_count), .stall_count(stall_count)
`endif
    );

    initial clock = 1'b0;
    always #5 clock = ~clock;

    int checks = 0;
    int errors = 0;

    // Reference model state: number of upcoming sampling edges still wrong-path
    int          ignore_left = 0;
    longint      model_taken = 0;
    longint      model_stalls = 0;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s: got 0x%08h expected 0x%08h at %0t", tag, got, exp, $time);
        end
    endtask

    task automatic check_all(input string tag, input bit e_succ, input logic [31:0] e_new,
                             input bit e_flush, input bit e_stall, input bit e_bubble,
                             input bit e_mis);
        check({tag, ".succ"},     32'(succ),     32'(e_succ));
        check({tag, ".new_addr"}, new_addr,      e_new);
        check({tag, ".flush"},    32'(flush),    32'(e_flush));
        check({tag, ".stall"},    32'(stall),    32'(e_stall));
        check({tag, ".bubble"},   32'(bubble),   32'(e_bubble));
        check({tag, ".misalign"}, 32'(misalign), 32'(e_mis));
    endtask

    task automatic idle_inputs();
        ex_valid = 0; ex_is_branch = 0; ex_is_jal = 0; ex_is_jalr = 0;
        ex_funct3 = 0; ex_rs1_val = 0; ex_rs2_val = 0; ex_imm = 0; ex_pc = 0;
        ex_is_load = 0; ex_rd = 0; id_rs1 = 0; id_rs2 = 0;
        id_uses_rs1 = 0; id_uses_rs2 = 0;
    endtask

    // Called at a negedge with inputs set: predicts, clocks one edge, compares
    task automatic cycle(input string tag);
        bit          e_succ, e_flush, e_stall, e_bubble, e_mis, taken, lu;
        logic [31:0] e_new, tgt;
        int          a, b;
        e_succ = 0; e_flush = 0; e_stall = 0; e_bubble = 0; e_mis = 0; e_new = 0;
        if (ignore_left > 0) begin
            ignore_left--;
        end else begin
            a = ex_rs1_val;
            b = ex_rs2_val;
            case (ex_funct3)
                3'd0: taken = (a == b);
                3'd1: taken = (a != b);
                3'd4: taken = (a < b);
                3'd5: taken = !(a < b);
                3'd6: taken = ({32'd0, ex_rs1_val} < {32'd0, ex_rs2_val});
                3'd7: taken = !({32'd0, ex_rs1_val} < {32'd0, ex_rs2_val});
                default: taken = 0;
            endcase
            taken = ex_valid && (ex_is_jal || ex_is_jalr || (ex_is_branch && taken));
            if (ex_is_jalr) tgt = (ex_rs1_val + ex_imm) & 32'hFFFF_FFFE;
            else            tgt = ex_pc + ex_imm;
            lu = ex_valid && ex_is_load && ex_rd != 0 &&
                 ((id_uses_rs1 && id_rs1 == ex_rd) || (id_uses_rs2 && id_rs2 == ex_rd));
            if (taken && (tgt % 4) < 2) begin
                e_succ = 1; e_flush = 1; e_new = tgt - ex_pc;
                ignore_left = FLUSH_DEPTH;
            end else if (taken) begin
                e_mis = 1;
            end else if (lu) begin
                e_stall = 1; e_bubble = 1;
            end
        end
        model_taken  += e_succ;
        model_stalls += e_stall;
        @(posedge clock);
        #1;
        check_all(tag, e_succ, e_new, e_flush, e_stall, e_bubble, e_mis);
`ifdef BRANCH_STATS_EN
        check({tag, ".taken_count"}, taken_count, 32'(model_taken));
        check({tag, ".stall_count"}, stall_count, 32'(model_stalls));
`endif
        @(negedge clock);
    endtask

    task automatic model_reset();
        ignore_left  = 0;
        model_taken  = 0;
        model_stalls = 0;
    endtask

    task automatic set_branch(input logic [2:0] f3, input logic [31:0] r1, input logic [31:0] r2,
                              input logic [31:0] imm, input logic [31:0] pc);
        idle_inputs();
        ex_valid = 1; ex_is_branch = 1; ex_funct3 = f3;
        ex_rs1_val = r1; ex_rs2_val = r2; ex_imm = imm; ex_pc = pc;
    endtask

    task automatic rand_inputs();
        logic [31:0] pool [5];
        int op;
        idle_inputs();
        pool[0] = 0; pool[1] = 1; pool[2] = 32'hFFFF_FFFF; pool[3] = 32'h8000_0000;
        pool[4] = $urandom;
        op = $urandom_range(0, 4);
        ex_valid     = ($urandom % 5) != 0;
        ex_is_branch = (op == 1);
        ex_is_jal    = (op == 2);
        ex_is_jalr   = (op == 3);
        ex_funct3    = 3'($urandom);
        ex_rs1_val   = (op == 3) ? $urandom : pool[$urandom_range(0, 4)];
        ex_rs2_val   = ($urandom % 3 == 0) ? ex_rs1_val : pool[$urandom_range(0, 4)];
        ex_imm       = ($urandom % 4 != 0) ? ($urandom & 32'hFFFF_FFFC) : ($urandom & 32'hFFFF_FFFE);
        ex_pc        = $urandom & 32'hFFFF_FFFC;
        ex_is_load   = ($urandom % 2) == 0;
        ex_rd        = 5'($urandom_range(0, 3));
        id_rs1       = 5'($urandom_range(0, 3));
        id_rs2       = 5'($urandom_range(0, 3));
        id_uses_rs1  = 1'($urandom);
        id_uses_rs2  = 1'($urandom);
    endtask

    initial begin
        idle_inputs();
        reset = 1;
        #12;
        check_all("reset", 0, 0, 0, 0, 0, 0);
        @(negedge clock);
        reset = 0;
        model_reset();

        // BEQ taken, then a taken branch held through the squash window
        set_branch(3'b000, 5, 5, 32'h20, 32'h0040_0010);
        cycle("beq_taken");
        check("beq_new_addr_const", new_addr, 32'h20);
        cycle("beq_squash1");
        cycle("beq_squash2");
        cycle("beq_rerun");
        check("beq_rerun_succ_const", 32'(succ), 32'd1);
        idle_inputs(); cycle("idle"); cycle("idle"); cycle("idle");

        // Signed vs unsigned less-than
        set_branch(3'b100, 32'hFFFF_FFFF, 1, 32'h40, 32'h0000_1000);
        cycle("blt_taken");
        check("blt_succ_const", 32'(succ), 32'd1);
        idle_inputs(); cycle("idle"); cycle("idle");
        set_branch(3'b110, 32'hFFFF_FFFF, 1, 32'h40, 32'h0000_1000);
        cycle("bltu_not_taken");
        check("bltu_succ_const", 32'(succ), 32'd0);
        set_branch(3'b010, 3, 3, 32'h8, 32'h0000_2000);
        cycle("undef_f3");

        // JALR alignment
        idle_inputs();
        ex_valid = 1; ex_is_jalr = 1; ex_rs1_val = 32'h0040_0101; ex_pc = 32'h0040_0040;
        cycle("jalr_aligned");
        check("jalr_new_addr_const", new_addr, 32'h0000_00C0);
        idle_inputs(); cycle("idle"); cycle("idle");
        ex_valid = 1; ex_is_jalr = 1; ex_rs1_val = 32'h0040_0102; ex_pc = 32'h0040_0040;
        cycle("jalr_misalign");
        check("jalr_misalign_const", 32'(misalign), 32'd1);

        // Load-use, held for back-to-back stalls, then rd = x0
        idle_inputs();
        ex_valid = 1; ex_is_load = 1; ex_rd = 7; id_rs2 = 7; id_uses_rs2 = 1;
        cycle("load_use");
        check("load_use_stall_const", 32'(stall), 32'd1);
        cycle("load_use_held");
        ex_rd = 0; id_rs2 = 0;
        cycle("load_use_x0");

        // JAL wins over a simultaneous load-use
        idle_inputs();
        ex_valid = 1; ex_is_jal = 1; ex_imm = 32'hFFFF_FFF0; ex_pc = 32'h0000_0100;
        ex_is_load = 1; ex_rd = 3; id_rs1 = 3; id_uses_rs1 = 1;
        cycle("jal_vs_load_use");
        check("jal_prio_stall_const", 32'(stall), 32'd0);
        idle_inputs(); cycle("idle"); cycle("idle");

        // Asynchronous reset during the first squash cycle
        set_branch(3'b001, 1, 2, 32'h100, 32'h0000_0400);
        cycle("bne_taken");
        #2;
        reset = 1;
        #1;
        check_all("reset_mid_squash", 0, 0, 0, 0, 0, 0);
        model_reset();
        @(negedge clock);
        reset = 0;
        set_branch(3'b101, 9, 2, 32'h8, 32'h0000_0800);
        cycle("bge_after_reset");
        check("bge_after_reset_const", 32'(succ), 32'd1);
        idle_inputs(); cycle("idle"); cycle("idle");

        // Random traffic
        for (int i = 0; i < 3000; i++) begin
            rand_inputs();
            cycle("rand");
        end

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

    // Global watchdog
    initial begin
        #2000000;
        $display("FAIL watchdog: simulation did not complete, got timeout expected finish");
        $fatal(1);
    end

endmodule
